// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states, opcodes,
// datapath select encodings and the per-state control-word decode.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_R     = 2'd1,
        CLS_I     = 2'd2
    } op_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // fetch / retire_on_ready / branch are qualified later by MemReady or the branch outcome.
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       fetch;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       retire;
        logic       retire_on_ready;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e st, input logic is_store,
                                         input logic [3:0] exec_alu);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.result_src = RES_ALURESULT;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_ctrl   = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_B;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = is_store ? IMM_S : IMM_I;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req         = 1'b1;
                c.adr_src         = 1'b1;
                c.mem_write       = 1'b1;
                c.retire_on_ready = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_ctrl  = exec_alu;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_ctrl  = exec_alu;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_ctrl   = ALU_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.retire     = 1'b1;
            end
            S_JAL, S_JALR2: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_ctrl   = ALU_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_JALR1: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_ctrl  = ALU_ADD;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R- and I-type arithmetic; flags ops the configured
// ALUControl width cannot express so the FSM can trap them.
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  logic [1:0]        op_class_i,
    input  logic [2:0]        fun3_i,
    input  logic              fun75_i,
    output logic [ALUC_W-1:0] alu_control_o,
    output logic              unsupported_o
);

    logic [3:0] code_s;
    logic       narrow_ok_s;
    logic       unsupported_s;

    // Full-width op selection; fun75 only means sub for register-register adds.
    always_comb begin
        code_s = ALU_ADD;
        case (fun3_i)
            3'b000:  code_s = (op_class_i == CLS_R && fun75_i) ? ALU_SUB : ALU_ADD;
            3'b001:  code_s = ALU_SLL;
            3'b010:  code_s = ALU_SLT;
            3'b011:  code_s = ALU_SLTU;
            3'b100:  code_s = ALU_XOR;
            3'b101:  code_s = fun75_i ? ALU_SRA : ALU_SRL;
            3'b110:  code_s = ALU_OR;
            3'b111:  code_s = ALU_AND;
            default: code_s = ALU_ADD;
        endcase
    end

    // Narrow ALU implements only add/sub/and/or/slt.
    always_comb begin
        narrow_ok_s   = (code_s == ALU_ADD) || (code_s == ALU_SUB) || (code_s == ALU_AND) ||
                        (code_s == ALU_OR)  || (code_s == ALU_SLT);
        unsupported_s = (op_class_i != CLS_OTHER) && (ALUC_W < 4) && !narrow_ok_s;
        unsupported_o = unsupported_s;
        alu_control_o = unsupported_s ? '0 : code_s[ALUC_W-1:0];
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RV32I core: sequences fetch through
// writeback over a shared ALU and a single memory port with a ready handshake.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int ALUC_W      = 4,
    parameter bit FULL_BRANCH = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [6:0]        Op,
    input  logic [2:0]        fun3,
    input  logic              fun75,
    input  logic              Zero,
    input  logic              Neg,
    input  logic              Carry,
    input  logic              OverFlow,
    input  logic              MemReady,
    output logic              MemReq,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              Illegal,
    output logic              Retire
);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q;
    op_class_e         op_class_s;
    logic [ALUC_W-1:0] dec_alu_s;
    logic [3:0]        exec_alu_s;
    logic              unsupported_s;
    logic              branch_ok_s;
    logic              taken_s;
    logic              run_s;

    // Classify the opcode for the ALU decoder.
    always_comb begin
        case (Op)
            OP_R:    op_class_s = CLS_R;
            OP_I:    op_class_s = CLS_I;
            default: op_class_s = CLS_OTHER;
        endcase
    end

    alu_decoder #(
        .ALUC_W(ALUC_W)
    ) u_alu_decoder (
        .op_class_i   (op_class_s),
        .fun3_i       (fun3),
        .fun75_i      (fun75),
        .alu_control_o(dec_alu_s),
        .unsupported_o(unsupported_s)
    );

    assign exec_alu_s = 4'(dec_alu_s);

    // Branch support and outcome; Carry=1 means the subtraction did not borrow.
    always_comb begin
        case (fun3)
            3'b000:  begin branch_ok_s = 1'b1;        taken_s = Zero;               end
            3'b001:  begin branch_ok_s = 1'b1;        taken_s = ~Zero;              end
            3'b100:  begin branch_ok_s = FULL_BRANCH; taken_s = Neg ^ OverFlow;     end
            3'b101:  begin branch_ok_s = FULL_BRANCH; taken_s = ~(Neg ^ OverFlow);  end
            3'b110:  begin branch_ok_s = FULL_BRANCH; taken_s = ~Carry;             end
            3'b111:  begin branch_ok_s = FULL_BRANCH; taken_s = Carry;              end
            default: begin branch_ok_s = 1'b0;        taken_s = 1'b0;               end
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = unsupported_s ? S_TRAP : S_EXECR;
                    OP_I:              state_d = unsupported_s ? S_TRAP : S_EXECI;
                    OP_BRANCH:         state_d = branch_ok_s ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR1:    state_d = S_JALR2;
            S_JALR2:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with the control word for the upcoming state registered alongside it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH, 1'b0, ALU_ADD);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, Op == OP_STORE, exec_alu_s);
        end
    end

    // Output stage: reset forces everything low, handshake terms qualify the registered word.
    always_comb begin
        run_s      = ~Rst;
        MemReq     = run_s & ctrl_q.mem_req;
        AdrSrc     = run_s & ctrl_q.adr_src;
        MemWrite   = run_s & ctrl_q.mem_write;
        IRWrite    = run_s & ctrl_q.fetch & MemReady;
        PCWrite    = run_s & (ctrl_q.pc_write | (ctrl_q.fetch & MemReady) |
                              (ctrl_q.branch & taken_s));
        RegWrite   = run_s & ctrl_q.reg_write;
        ResultSrc  = run_s ? ctrl_q.result_src : 2'b00;
        ALUSrcA    = run_s ? ctrl_q.alu_src_a : 2'b00;
        ALUSrcB    = run_s ? ctrl_q.alu_src_b : 2'b00;
        ImmSrc     = run_s ? ctrl_q.imm_src : 2'b00;
        ALUControl = run_s ? ctrl_q.alu_ctrl[ALUC_W-1:0] : '0;
        Illegal    = run_s & ctrl_q.illegal;
        Retire     = run_s & (ctrl_q.retire | (ctrl_q.retire_on_ready & MemReady));
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-FSM control unit for the next-generation multi-cycle RV32I core. Replaces the combinational single-cycle decoder.
- Sequences fetch/decode/execute/memory/writeback over several cycles and reuses one ALU and one unified memory port.
- Adds a memory-ready handshake, full branch-condition set, illegal-instruction trap, and a retire pulse.
- Drives the shared execution datapath; reads instruction fields from its IR and flags from its ALU.

Parameters:
- ALUC_W, 4, ALUControl width: 4 gives the full op set; 3 gives add/sub/and/or/slt only, all other ops trap.
- FULL_BRANCH, 1, 1 supports all six B-type conditions; 0 supports beq/bne only, other fun3 values trap.

Ports:
- Clk  in  1  core clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Op  in  7  Instr[6:0].
- fun3  in  3  Instr[14:12].
- fun75  in  1  Instr[30].
- Zero, Neg, Carry, OverFlow  in  1 each  ALU flags, valid in the cycle they are used.
- MemReady  in  1  memory completes the request this cycle.
- MemReq  out  1  memory access request.
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  store strobe.
- IRWrite  out  1  instruction-register load.
- PCWrite  out  1  PC load.
- RegWrite  out  1  register-file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  ALUC_W  add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001 (ALUC_W=3 uses the low 3 bits).
- Illegal  out  1  trap indicator.
- Retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Reset: while Rst=1, all outputs are 0. Next state is FETCH, overriding any state, including mid-access.
- Outputs are decoded from state only. Exception: PCWrite = PCUpdate | (Branch & taken).
- Don't-care outputs are driven 0.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite=PCUpdate=MemReady.
  - Hold while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=B (branch target into ALUOut). Next state by Op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - any other Op, or unsupported fun3/fun75 under the parameters -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc = I for lw, S for sw. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq=1, AdrSrc=1. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next: FETCH.
- MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1. Hold until MemReady; on MemReady, Retire=1 and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from fun3/fun75. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I.
  - fun75 selects sra only when fun3=101; for fun3=000 the op is always add.
  - Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1, Retire=1. Next: FETCH.
  - taken per fun3: 000 Zero; 001 ~Zero; 100 Neg^OverFlow; 101 ~(Neg^OverFlow); 110 ~Carry; 111 Carry.
  - Carry=1 means no borrow.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB, which writes PC+4 to rd.
- JALR1: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add. Next: JALR2.
- JALR2: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB. The datapath clears bit 0 of the target.
- TRAP: Illegal=1; all write/request outputs 0. Absorbing state; only Rst leaves it.
- Latency in cycles with zero wait states:
  - lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5.
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUControl, ImmSrc, ResultSrc and ALUSrc encodings
- Sub-module alu_decoder (combinational): inputs Op class, fun3, fun75; outputs ALUControl and Unsupported. It is parametrised by ALUC_W.
- Branch-condition logic stays inline in the FSM.

Test Plan:
- Rst=1 for 2 cycles, then add x1,x2,x3 with MemReady=1:
  - all outputs are 0 during reset
  - FETCH, DECODE, EXECR, ALUWB follow; ALUControl=0000 in EXECR
  - RegWrite and Retire are high only in cycle 4
- lw with MemReady held 0 for 3 cycles in FETCH and 2 cycles in MEMREAD -> retire at cycle 10; IRWrite pulses exactly once.
- blt (fun3=100) with Neg=1, OverFlow=0 -> PCWrite=1 in BRANCH. Repeat with Neg=1, OverFlow=1 -> PCWrite=0. Both retire in 3 cycles.
- FULL_BRANCH=0 with bgeu -> Illegal=1 from the cycle after DECODE and stays high for 20 cycles; Rst then returns the FSM to FETCH.
- ALUC_W=3 with xor (fun3=100) -> TRAP. ALUC_W=4 with sra (fun3=101, fun75=1) -> ALUControl=1001.
- jalr, with Rst asserted during JALR2 -> no RegWrite occurs and the next state is FETCH.
